// File: rtl/reu_dma_seq_if.sv
// Bus bundle between the REU register file / SDRAM controller and the DMA sequencer.
// The slave modport is the sequencer's view; master is the driving side.
interface reu_dma_seq_if #(parameter int LEN_W = 16);
    logic             BA;
    logic             RAMRdy;
    logic             Execute;
    logic [1:0]       XferType;
    logic             FixC64;
    logic             FixREU;
    logic             Autoload;
    logic [LEN_W-1:0] LenIn;
    logic             Equal;

    logic             DMA;
    logic             DMARW;
    logic             RAMRD;
    logic             RAMWR;
    logic             NextCA;
    logic             NextREUA;
    logic             Reload;
    logic             XferEnd;
    logic             VerifyErr;
    logic             Busy;
    logic [LEN_W-1:0] LenOut;

    modport master (
        output BA, RAMRdy, Execute, XferType, FixC64, FixREU, Autoload, LenIn, Equal,
        input  DMA, DMARW, RAMRD, RAMWR, NextCA, NextREUA, Reload, XferEnd, VerifyErr, Busy, LenOut
    );

    modport slave (
        input  BA, RAMRdy, Execute, XferType, FixC64, FixREU, Autoload, LenIn, Equal,
        output DMA, DMARW, RAMRD, RAMWR, NextCA, NextREUA, Reload, XferEnd, VerifyErr, Busy, LenOut
    );
endinterface

// File: rtl/reu_dma_seq.sv
// REU DMA sequencer: C64<->SDRAM copy, swap and verify with an internal length counter.
// All state moves on the falling edge of PHI2; RESET is synchronous and active high.
module reu_dma_seq #(
    parameter int LEN_W = 16
) (
    input  logic          PHI2,
    input  logic          RESET,
    reu_dma_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, XFER, FLUSH} state_e;
    typedef enum logic [1:0] {C64REU = 2'b00, REUC64 = 2'b01, SWAP = 2'b10, VERIFY = 2'b11} kind_e;

    state_e           state, nextState;
    kind_e            kind;
    logic             fixC64, fixREU, autoLd;
    logic             wrPend, phase, verifyErr, reloadQ;
    logic [LEN_W-1:0] lenCnt;

    logic active, wrFire, complete, mismatch, lastElem;
    logic dmaRw, ramRd, ramWr, nextCa, nextReua, xferEnd;

    assign active   = (state == XFER) && bus.BA && bus.RAMRdy;
    // The trailing C64->REU write only needs the SDRAM, not the C64 bus.
    assign wrFire   = wrPend && bus.RAMRdy && (state != IDLE);
    assign complete = active && ((kind != SWAP) || phase);
    assign mismatch = active && (kind == VERIFY) && !bus.Equal;
    assign lastElem = complete && ((lenCnt == LEN_W'(1)) || mismatch);

    always_comb begin
        nextState = state;
        dmaRw     = 1'b0;
        ramRd     = 1'b0;
        ramWr     = 1'b0;
        nextCa    = 1'b0;
        nextReua  = 1'b0;
        xferEnd   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Execute) nextState = XFER;
            end
            XFER: begin
                xferEnd = lastElem;
                nextCa  = complete && !fixC64;
                case (kind)
                    C64REU: begin
                        dmaRw    = 1'b1;
                        ramWr    = wrFire;
                        nextReua = wrFire && !fixREU;
                    end
                    REUC64: begin
                        ramRd    = active;
                        nextReua = complete && !fixREU;
                    end
                    SWAP: begin
                        dmaRw    = !phase;
                        ramRd    = active && !phase;
                        ramWr    = active && phase;
                        nextReua = complete && !fixREU;
                    end
                    VERIFY: begin
                        dmaRw    = 1'b1;
                        ramRd    = active;
                        nextReua = complete && !fixREU;
                    end
                endcase
                if (lastElem) nextState = (kind == C64REU) ? FLUSH : IDLE;
            end
            FLUSH: begin
                ramWr    = wrFire;
                nextReua = wrFire && !fixREU;
                if (bus.RAMRdy) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(negedge PHI2) begin
        if (RESET) begin
            state     <= IDLE;
            kind      <= C64REU;
            fixC64    <= 1'b0;
            fixREU    <= 1'b0;
            autoLd    <= 1'b0;
            wrPend    <= 1'b0;
            phase     <= 1'b0;
            verifyErr <= 1'b0;
            reloadQ   <= 1'b0;
            lenCnt    <= '0;
        end else begin
            state   <= nextState;
            reloadQ <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Execute) begin
                        kind      <= kind_e'(bus.XferType);
                        fixC64    <= bus.FixC64;
                        fixREU    <= bus.FixREU;
                        autoLd    <= bus.Autoload;
                        lenCnt    <= bus.LenIn;
                        verifyErr <= 1'b0;
                        phase     <= 1'b0;
                        wrPend    <= 1'b0;
                    end
                end
                XFER: begin
                    if (kind == C64REU) wrPend <= active || (wrPend && !wrFire);
                    if (active && (kind == SWAP)) phase <= !phase;
                    if (mismatch) verifyErr <= 1'b1;
                    // The counter parks at 1 after a full run, like the original REU.
                    if (complete && (lenCnt != LEN_W'(1))) lenCnt <= lenCnt - LEN_W'(1);
                    if (lastElem && autoLd) begin
                        lenCnt <= bus.LenIn;
                        if (kind != C64REU) reloadQ <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (wrFire) wrPend <= 1'b0;
                    if (bus.RAMRdy && autoLd) reloadQ <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.DMA       = (state == XFER);
    assign bus.Busy      = (state != IDLE);
    assign bus.DMARW     = dmaRw;
    assign bus.RAMRD     = ramRd;
    assign bus.RAMWR     = ramWr;
    assign bus.NextCA    = nextCa;
    assign bus.NextREUA  = nextReua;
    assign bus.XferEnd   = xferEnd;
    assign bus.Reload    = reloadQ;
    assign bus.VerifyErr = verifyErr || mismatch;
    assign bus.LenOut    = lenCnt;
endmodule
